capi_cmd_credit_mc: RTL and testbench
=====================================

Name: capi_cmd_credit_mc

Overview:
- Multi-channel command credit manager; successor to the single-counter credit block.
- Tracks one credit pool per command channel and gates each channel's command issue.
- Adds run-time reload, saturation, sticky error flags and a low-priority reserve threshold.
- Sits between the PSL credit-return interface and the per-channel command arbiters.

Parameters:
channels, 4, number of independent credit pools
cred_width, 9, bits per credit counter; max count 2^cred_width-1
ld_delay, 10, cycles from load trigger to initial/reload value written (≥1)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-low
i_init_cred  in  channels*cred_width  initial credit per channel, ch0 in MSBs
i_reload  in  1  pulse: reload all channels from i_init_cred
i_cred_add_v  in  channels  bulk credit return valid
i_cred_add_d  in  channels*cred_width  bulk credit return amount
i_cred_inc_v  in  channels  single credit return
i_cred_dec_v  in  channels  credit consumed (command issued)
i_rsv  in  cred_width  reserve threshold for low-priority issue, shared by all channels
o_en  out  channels  channel has ≥1 credit and no load pending
o_en_lp  out  channels  channel has credits > i_rsv and no load pending
o_credits  out  channels*cred_width  registered copy of counters
o_err  out  channels  sticky: underflow or overflow seen on that channel
o_init_done  out  1  high once first load has completed

Behaviour:
- Reset asserted: all counters 0, staging regs 0, o_en/o_en_lp/o_err/o_credits/o_init_done 0, load pipe cleared.
- Load trigger: one-shot on the first clock after reset deassertion; also on each cycle i_reload=1. Trigger passes through an ld_delay-stage shift pipe; counters load i_init_cred in the cycle the pipe output is 1.
- ld_pend = any stage of the load pipe set; while ld_pend, o_en and o_en_lp are forced 0.
- o_init_done sets in the cycle after the first load; it clears only on reset.
- Return staging per channel: s1 = (add_v ? add_d : 0) + (inc_v ? 1 : 0), computed cred_width+1 bits wide and registered. Net returns reach the counter 2 cycles after input.
- Counter update: nxt = crd + s1 − dec_v, computed cred_width+2 bits wide and signed.
  - nxt > 2^cred_width−1: counter saturates to max; o_err set.
  - nxt < 0 (dec with crd+s1 = 0): counter stays 0; o_err set.
  - Load cycle: counter = i_init_cred; s1 and dec for that cycle are discarded; no error is raised.
- Same-cycle s1 and dec combine arithmetically, so a dec at crd=0 is legal if s1 ≥ 1.
- o_en = |crd & ~ld_pend; o_en_lp = (crd > i_rsv) & ~ld_pend; both combinational from the counter register.
- A dec at t affects o_en at t+1. An add/inc at t affects o_en at t+2. o_credits lags crd by 1 cycle.
- Channels are fully independent except for the shared load trigger and i_rsv.
- i_reload while a load is pending: a second load happens ld_delay cycles after the later pulse; both loads occur.

Decomposition:
- Shared package/header holds: CRED_ZRO, CRED_ONE, CRED_MAX localparams, and a slice macro/function for channel c of a packed bus.
- Sub-module capi_cmd_credit_chan holds one channel: staging reg, counter, saturation, error and enable logic.
- Top holds the one-shot, reload OR, load delay pipe, ld_pend and o_init_done, and a generate loop over channels.

Test Plan:
- Reset release, i_init_cred ch0..3 = 16,8,0,511, ld_delay=10 -> o_en=0 for cycles 1..10; at cycle 11 o_en=1101; o_credits = 16,8,0,511 at cycle 12; o_init_done=1.
- ch0=16: 16 back-to-back dec -> o_en[0] drops the cycle after the 16th dec; a 17th dec -> counter stays 0, o_err[0]=1 sticky.
- ch3=511: inc pulse -> counter 511, o_err[3]=1. ch1=8: add_d=5 plus inc in same cycle -> 14 two cycles later.
- ch1=1: dec at t with inc at t−2 -> counter 1, no error. i_rsv=4, ch1=5 -> o_en_lp[1]=1; one dec -> o_en_lp[1]=0, o_en[1]=1.
- Mid-run i_reload pulse with add_v on ch0 landing on the load cycle -> o_en=0 for ld_delay cycles; counters equal i_init_cred exactly; add discarded.
- Reset asserted asynchronously mid-count -> all outputs 0 immediately; after release the full load sequence repeats and o_err is cleared.

Source files
------------

// File: rtl/capi_cmd_credit_mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | capi_cmd_credit_mc_pkg : shared constants and bus-slice helper      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package capi_cmd_credit_mc_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int CRED_W       = 9;
  localparam int LD_DELAY_DEF = 10;

  localparam int CRED_ZRO = 0;
  localparam int CRED_ONE = 1;
  localparam int CRED_MAX = (1 << CRED_W) - 1;

  // Channel 0 occupies the most significant field of a packed per-channel bus.
  function automatic int chan_lsb(input int c, input int n, input int w);
    return (n - 1 - c) * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capi_cmd_credit_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | capi_cmd_credit_chan : one credit pool with staging and saturation  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module capi_cmd_credit_chan
  import capi_cmd_credit_mc_pkg::*;
#(
  parameter int CRED_WIDTH = CRED_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ld,
  input  logic                  i_ld_pend,
  input  logic [CRED_WIDTH-1:0] i_init,
  input  logic                  i_add_v,
  input  logic [CRED_WIDTH-1:0] i_add_d,
  input  logic                  i_inc_v,
  input  logic                  i_dec_v,
  input  logic [CRED_WIDTH-1:0] i_rsv,
  output logic                  o_en,
  output logic                  o_en_lp,
  output logic [CRED_WIDTH-1:0] o_credits,
  output logic                  o_err
);

  localparam logic [CRED_WIDTH-1:0] c_ZRO = CRED_WIDTH'(CRED_ZRO);
  localparam logic [CRED_WIDTH:0]   c_ONE = (CRED_WIDTH+1)'(CRED_ONE);
  localparam logic [CRED_WIDTH-1:0] c_MAX = {CRED_WIDTH{1'b1}};

  logic        [CRED_WIDTH:0]   r_s1;
  logic        [CRED_WIDTH-1:0] r_crd;
  logic        [CRED_WIDTH-1:0] r_credits;
  logic                         r_err;
  logic        [CRED_WIDTH:0]   w_s1_nxt;
  logic signed [CRED_WIDTH+1:0] w_nxt;
  logic                         w_ovf;
  logic                         w_unf;

  // Two guard bits: one for add+inc carry, one for the sign of an underflow.
  always_comb begin
    w_s1_nxt = i_add_v ? {1'b0, i_add_d} : '0;
    if (i_inc_v) w_s1_nxt = w_s1_nxt + c_ONE;
    w_nxt = $signed({2'b00, r_crd}) + $signed({1'b0, r_s1})
          - $signed({{(CRED_WIDTH+1){1'b0}}, i_dec_v});
    w_ovf = w_nxt > $signed({2'b00, c_MAX});
    w_unf = w_nxt[CRED_WIDTH+1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_crd     <= c_ZRO;
      r_credits <= c_ZRO;
      r_err     <= 1'b0;
    end else begin
      r_s1      <= w_s1_nxt;
      r_credits <= r_crd;
      if (i_ld) begin
        r_crd <= i_init;
      end else if (w_ovf) begin
        r_crd <= c_MAX;
        r_err <= 1'b1;
      end else if (w_unf) begin
        r_crd <= c_ZRO;
        r_err <= 1'b1;
      end else begin
        r_crd <= w_nxt[CRED_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    o_en      = (|r_crd) & ~i_ld_pend;
    o_en_lp   = (r_crd > i_rsv) & ~i_ld_pend;
    o_credits = r_credits;
    o_err     = r_err;
  end

endmodule
`default_nettype wire

// File: rtl/capi_cmd_credit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | capi_cmd_credit_mc : multi-channel command credit manager           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module capi_cmd_credit_mc
  import capi_cmd_credit_mc_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_DEF,
  parameter int CRED_WIDTH = CRED_W,
  parameter int LD_DELAY   = LD_DELAY_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*CRED_WIDTH-1:0] i_init_cred,
  input  logic                           i_reload,
  input  logic [CHANNELS-1:0]            i_cred_add_v,
  input  logic [CHANNELS*CRED_WIDTH-1:0] i_cred_add_d,
  input  logic [CHANNELS-1:0]            i_cred_inc_v,
  input  logic [CHANNELS-1:0]            i_cred_dec_v,
  input  logic [CRED_WIDTH-1:0]          i_rsv,
  output logic [CHANNELS-1:0]            o_en,
  output logic [CHANNELS-1:0]            o_en_lp,
  output logic [CHANNELS*CRED_WIDTH-1:0] o_credits,
  output logic [CHANNELS-1:0]            o_err,
  output logic                           o_init_done
);

  logic                r_started;
  logic [LD_DELAY-1:0] r_ld_pipe;
  logic                r_init_done;
  logic                w_trig;
  logic                w_ld;
  logic                w_ld_pend;

  // The first clock after reset release acts as an implicit reload.
  always_comb begin
    w_trig    = ~r_started | i_reload;
    w_ld      = r_ld_pipe[LD_DELAY-1];
    w_ld_pend = |r_ld_pipe;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_started   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_started   <= 1'b1;
      r_init_done <= r_init_done | w_ld;
    end
  end

  if (LD_DELAY == 1) begin : g_pipe_one
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ld_pipe <= '0;
      else        r_ld_pipe <= w_trig;
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ld_pipe <= '0;
      else        r_ld_pipe <= {r_ld_pipe[LD_DELAY-2:0], w_trig};
    end
  end

  assign o_init_done = r_init_done;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam int c_LSB = chan_lsb(c, CHANNELS, CRED_WIDTH);
    localparam int c_BIT = chan_lsb(c, CHANNELS, 1);

    capi_cmd_credit_chan #(
      .CRED_WIDTH (CRED_WIDTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_ld      (w_ld),
      .i_ld_pend (w_ld_pend),
      .i_init    (i_init_cred[c_LSB +: CRED_WIDTH]),
      .i_add_v   (i_cred_add_v[c_BIT]),
      .i_add_d   (i_cred_add_d[c_LSB +: CRED_WIDTH]),
      .i_inc_v   (i_cred_inc_v[c_BIT]),
      .i_dec_v   (i_cred_dec_v[c_BIT]),
      .i_rsv     (i_rsv),
      .o_en      (o_en[c_BIT]),
      .o_en_lp   (o_en_lp[c_BIT]),
      .o_credits (o_credits[c_LSB +: CRED_WIDTH]),
      .o_err     (o_err[c_BIT])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_capi_cmd_credit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_capi_cmd_credit_mc : scoreboard bench for the credit manager     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_capi_cmd_credit_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] i_init_cred;
  logic        i_reload;
  logic [3:0]  i_cred_add_v;
  logic [35:0] i_cred_add_d;
  logic [3:0]  i_cred_inc_v;
  logic [3:0]  i_cred_dec_v;
  logic [8:0]  i_rsv;
  logic [3:0]  o_en;
  logic [3:0]  o_en_lp;
  logic [35:0] o_credits;
  logic [3:0]  o_err;
  logic        o_init_done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [3:0]  q_en[$];
  logic [35:0] q_cred[$];
  logic [3:0]  q_err[$];

  capi_cmd_credit_mc #(
    .CHANNELS   (4),
    .CRED_WIDTH (9),
    .LD_DELAY   (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_init_cred  (i_init_cred),
    .i_reload     (i_reload),
    .i_cred_add_v (i_cred_add_v),
    .i_cred_add_d (i_cred_add_d),
    .i_cred_inc_v (i_cred_inc_v),
    .i_cred_dec_v (i_cred_dec_v),
    .i_rsv        (i_rsv),
    .o_en         (o_en),
    .o_en_lp      (o_en_lp),
    .o_credits    (o_credits),
    .o_err        (o_err),
    .o_init_done  (o_init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {9'(a), 9'(b), 9'(c), 9'(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    i_reload     = 1'b0;
    i_cred_add_v = '0;
    i_cred_add_d = '0;
    i_cred_inc_v = '0;
    i_cred_dec_v = '0;
  endtask

  // Bit order of all per-channel vectors: ch0 = bit 3 ... ch3 = bit 0.
  task automatic load_sequence(input logic [35:0] init, input logic [3:0] en_exp, input string tag);
    logic [3:0]  e;
    logic [35:0] ec;
    for (int k = 1; k <= 11; k++) begin
      q_en.push_back(k == 11 ? en_exp : 4'b0000);
      tick();
      e = q_en.pop_front();
      total++;
      if (o_en !== e) $display("FAIL %s_en_k%0d: got %b expected %b", tag, k, o_en, e);
      else passed++;
      if (k == 10) begin
        total++;
        if (o_init_done !== 1'b0) $display("FAIL %s_init_early: got %b expected 0", tag, o_init_done);
        else passed++;
      end
    end
    q_cred.push_back(init);
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL %s_credits: got %h expected %h", tag, o_credits, ec);
    else passed++;
    total++;
    if (o_init_done !== 1'b1) $display("FAIL %s_init_done: got %b expected 1", tag, o_init_done);
    else passed++;
    total++;
    if (o_err !== 4'b0000) $display("FAIL %s_err: got %b expected 0000", tag, o_err);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    i_init_cred = pack4(16, 8, 0, 511);
    i_rsv = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_en, o_en_lp, o_err, o_init_done} !== 13'b0)
      $display("FAIL rst_flags: got %b expected 0", {o_en, o_en_lp, o_err, o_init_done});
    else passed++;
    total++;
    if (o_credits !== 36'b0) $display("FAIL rst_credits: got %h expected 0", o_credits);
    else passed++;
    reset = 1'b1;
    load_sequence(pack4(16, 8, 0, 511), 4'b1101, "init");
    total++;
    if (o_en_lp !== 4'b1101) $display("FAIL init_en_lp: got %b expected 1101", o_en_lp);
    else passed++;
  endtask

  task automatic test_add_overflow();
    logic [3:0]  e;
    logic [35:0] ec;
    i_cred_inc_v = 4'b0101;
    i_cred_add_v = 4'b0100;
    i_cred_add_d = pack4(0, 5, 0, 0);
    q_err.push_back(4'b0001);
    q_cred.push_back(pack4(16, 14, 0, 511));
    tick();
    clear_inputs();
    total++;
    if (o_err !== 4'b0000) $display("FAIL ovf_err_early: got %b expected 0000", o_err);
    else passed++;
    tick();
    e = q_err.pop_front();
    total++;
    if (o_err !== e) $display("FAIL ovf_err: got %b expected %b", o_err, e);
    else passed++;
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL add_inc_credits: got %h expected %h", o_credits, ec);
    else passed++;
  endtask

  task automatic test_drain();
    logic [3:0]  e;
    logic [35:0] ec;
    i_cred_dec_v = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      q_en.push_back({(16 - (i + 1)) > 0, 3'b101});
      tick();
      e = q_en.pop_front();
      total++;
      if (o_en !== e) $display("FAIL drain_en_%0d: got %b expected %b", i, o_en, e);
      else passed++;
    end
    q_err.push_back(4'b1001);
    tick();
    clear_inputs();
    e = q_err.pop_front();
    total++;
    if (o_err !== e) $display("FAIL unf_err: got %b expected %b", o_err, e);
    else passed++;
    q_cred.push_back(pack4(0, 14, 0, 511));
    repeat (3) tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL unf_credits: got %h expected %h", o_credits, ec);
    else passed++;
    total++;
    if (o_err !== 4'b1001) $display("FAIL err_sticky: got %b expected 1001", o_err);
    else passed++;
  endtask

  task automatic test_combine();
    logic [35:0] ec;
    i_cred_dec_v = 4'b0100;
    repeat (13) tick();
    i_cred_dec_v = 4'b0000;
    i_cred_inc_v = 4'b0100;
    tick();
    clear_inputs();
    tick();
    i_cred_dec_v = 4'b0100;
    q_cred.push_back(pack4(0, 1, 0, 511));
    tick();
    clear_inputs();
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL inc_then_dec: got %h expected %h", o_credits, ec);
    else passed++;
    // Channel 2 sits at zero: inc lands on the same edge as the following dec.
    i_cred_inc_v = 4'b0010;
    tick();
    i_cred_inc_v = 4'b0000;
    i_cred_dec_v = 4'b0010;
    tick();
    clear_inputs();
    q_cred.push_back(pack4(0, 1, 0, 511));
    repeat (2) tick();
    ec = q_cred.pop_front();
    total++;
    if (o_err !== 4'b1001) $display("FAIL zero_combine_err: got %b expected 1001", o_err);
    else passed++;
    total++;
    if (o_credits !== ec) $display("FAIL zero_combine_credits: got %h expected %h", o_credits, ec);
    else passed++;
  endtask

  task automatic test_reserve();
    logic [3:0] e;
    i_rsv = 9'd4;
    i_cred_add_v = 4'b0100;
    i_cred_add_d = pack4(0, 4, 0, 0);
    q_en.push_back(4'b0101);
    tick();
    clear_inputs();
    tick();
    e = q_en.pop_front();
    total++;
    if (o_en_lp !== e) $display("FAIL rsv_above: got %b expected %b", o_en_lp, e);
    else passed++;
    i_cred_dec_v = 4'b0100;
    q_en.push_back(4'b0001);
    tick();
    clear_inputs();
    e = q_en.pop_front();
    total++;
    if (o_en_lp !== e) $display("FAIL rsv_equal: got %b expected %b", o_en_lp, e);
    else passed++;
    total++;
    if (o_en !== 4'b0101) $display("FAIL rsv_en: got %b expected 0101", o_en);
    else passed++;
    i_rsv = 9'd0;
  endtask

  task automatic test_reload();
    logic [3:0]  e;
    logic [35:0] ec;
    i_init_cred = pack4(20, 3, 7, 100);
    i_reload = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      q_en.push_back(k == 11 ? 4'b1111 : 4'b0000);
      tick();
      if (k == 1) i_reload = 1'b0;
      e = q_en.pop_front();
      total++;
      if (o_en !== e) $display("FAIL reload_en_k%0d: got %b expected %b", k, o_en, e);
      else passed++;
      if (k == 9) begin
        i_cred_add_v = 4'b1000;
        i_cred_add_d = pack4(50, 0, 0, 0);
      end
      if (k == 10) clear_inputs();
    end
    q_cred.push_back(pack4(20, 3, 7, 100));
    q_cred.push_back(pack4(20, 3, 7, 100));
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL reload_credits: got %h expected %h", o_credits, ec);
    else passed++;
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL reload_add_discard: got %h expected %h", o_credits, ec);
    else passed++;
    total++;
    if (o_err !== 4'b1001) $display("FAIL reload_err: got %b expected 1001", o_err);
    else passed++;
  endtask

  task automatic test_double_reload();
    logic [3:0]  e;
    logic [35:0] ec;
    i_init_cred = pack4(1, 2, 3, 4);
    i_reload = 1'b1;
    q_cred.push_back(pack4(1, 2, 3, 4));
    q_cred.push_back(pack4(9, 0, 5, 6));
    for (int k = 1; k <= 14; k++) begin
      q_en.push_back(k == 14 ? 4'b1011 : 4'b0000);
      tick();
      if (k == 1 || k == 4) i_reload = 1'b0;
      if (k == 3) i_reload = 1'b1;
      e = q_en.pop_front();
      total++;
      if (o_en !== e) $display("FAIL dbl_en_k%0d: got %b expected %b", k, o_en, e);
      else passed++;
      if (k == 11) i_init_cred = pack4(9, 0, 5, 6);
      if (k == 12) begin
        ec = q_cred.pop_front();
        total++;
        if (o_credits !== ec) $display("FAIL dbl_first_load: got %h expected %h", o_credits, ec);
        else passed++;
      end
    end
    tick();
    ec = q_cred.pop_front();
    total++;
    if (o_credits !== ec) $display("FAIL dbl_second_load: got %h expected %h", o_credits, ec);
    else passed++;
  endtask

  task automatic test_async_reset();
    i_cred_dec_v = 4'b1000;
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({o_en, o_en_lp, o_err, o_init_done} !== 13'b0)
      $display("FAIL async_flags: got %b expected 0", {o_en, o_en_lp, o_err, o_init_done});
    else passed++;
    total++;
    if (o_credits !== 36'b0) $display("FAIL async_credits: got %h expected 0", o_credits);
    else passed++;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    load_sequence(pack4(9, 0, 5, 6), 4'b1011, "rerun");
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_drain();
    test_combine();
    test_reserve();
    test_reload();
    test_double_reload();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
